// File: rtl/alu_decode_issue.sv
// alu_decode_issue: decode/issue stage between instruction fetch and
// register-read/ALU. Decodes a 32-bit instruction word into ALU opcode,
// register indices and a sign-extended immediate, and issues entries through
// a 2-entry skid buffer with valid/ready on both sides. Also tracks HALT
// and discards buffered work on a branch flush.

package alu_decode_issue_pkg;

  // Instruction memory addresses are byte addresses of 32-bit words.
  typedef logic [31:0] instruction_memory_address_t;

  // ALU opcodes share their encoding with the instruction op field.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_ABS  = 5'd4,
    OP_SLT  = 5'd5,
    OP_SEQ  = 5'd6,
    OP_SNEZ = 5'd7,
    OP_MIN  = 5'd8,
    OP_SLL  = 5'd9,
    OP_ADDI = 5'd10,
    OP_MULI = 5'd11,
    OP_DIVI = 5'd12,
    OP_SLLI = 5'd13,
    OP_SEQI = 5'd14,
    OP_BEQO = 5'd15,
    OP_BEQZ = 5'd16,
    OP_JAL  = 5'd17,
    OP_HALT = 5'd31
  } alu_instruction_t;

endpackage

module alu_decode_issue
  import alu_decode_issue_pkg::*;
#(
  parameter int DATA_W     = 32,  // operand / immediate width
  parameter int REG_ADDR_W = 5,   // register index width
  parameter int SKID_DEPTH = 2    // output buffer entries; only 2 is supported
) (
  input  logic                        clk,
  input  logic                        reset,
  // fetch side
  input  logic                        in_valid,
  output logic                        in_ready,
  input  instruction_memory_address_t in_pc,
  input  logic [31:0]                 in_instr,
  // taken branch / jump: drop everything buffered
  input  logic                        flush,
  // issue side
  output logic                        out_valid,
  input  logic                        out_ready,
  output instruction_memory_address_t out_pc,
  output alu_instruction_t            out_op,
  output logic [REG_ADDR_W-1:0]       out_rd,
  output logic [REG_ADDR_W-1:0]       out_rs1,
  output logic [REG_ADDR_W-1:0]       out_rs2,
  output logic [DATA_W-1:0]           out_imm,
  output logic                        out_reg_write,
  output logic                        out_is_branch,
  output logic                        out_is_jump,
  output logic                        out_illegal,
  output logic                        halted
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  // One decoded instruction as it sits in the skid buffer.
  typedef struct packed {
    instruction_memory_address_t pc;
    alu_instruction_t            op;
    logic [REG_ADDR_W-1:0]       rd;
    logic [REG_ADDR_W-1:0]       rs1;
    logic [REG_ADDR_W-1:0]       rs2;
    logic [DATA_W-1:0]           imm;
    logic                        reg_write;
    logic                        is_branch;
    logic                        is_jump;
    logic                        illegal;
    logic                        is_halt;
  } entry_t;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_HALT_SEEN = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [4:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_f_rd;
  logic [REG_ADDR_W-1:0] w_f_rs1;
  logic [REG_ADDR_W-1:0] w_f_rs2;
  logic [DATA_W-1:0]     w_imm_short;
  logic [DATA_W-1:0]     w_imm_jal;
  entry_t                w_dec;

  assign w_opcode    = in_instr[31:27];
  assign w_f_rd      = REG_ADDR_W'(in_instr[26:22]);
  assign w_f_rs1     = REG_ADDR_W'(in_instr[21:17]);
  assign w_f_rs2     = REG_ADDR_W'(in_instr[16:12]);
  assign w_imm_short = {{(DATA_W-17){in_instr[16]}}, in_instr[16:0]};
  assign w_imm_jal   = {{(DATA_W-22){in_instr[21]}}, in_instr[21:0]};

  // Build the decoded entry; unused fields stay zero so the ALU sees clean operands.
  always_comb begin
    w_dec     = '0;
    w_dec.pc  = in_pc;
    w_dec.op  = OP_ADD;
    case (w_opcode)
      // R-type
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: begin
        w_dec.op        = alu_instruction_t'(w_opcode);
        w_dec.rd        = w_f_rd;
        w_dec.rs1       = w_f_rs1;
        // ABS and SNEZ are unary: the rs2 field carries no meaning
        w_dec.rs2       = (w_opcode == 5'd4 || w_opcode == 5'd7) ? '0 : w_f_rs2;
        w_dec.reg_write = 1'b1;
      end
      // I-type
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14: begin
        w_dec.op        = alu_instruction_t'(w_opcode);
        w_dec.rd        = w_f_rd;
        w_dec.rs1       = w_f_rs1;
        w_dec.imm       = w_imm_short;
        w_dec.reg_write = 1'b1;
      end
      // conditional branches: no destination register
      5'd15, 5'd16: begin
        w_dec.op        = alu_instruction_t'(w_opcode);
        w_dec.rs1       = w_f_rs1;
        w_dec.imm       = w_imm_short;
        w_dec.is_branch = 1'b1;
      end
      // JAL writes the link register, uses the long immediate
      5'd17: begin
        w_dec.op        = OP_JAL;
        w_dec.rd        = w_f_rd;
        w_dec.imm       = w_imm_jal;
        w_dec.reg_write = 1'b1;
        w_dec.is_jump   = 1'b1;
      end
      // HALT issues as a harmless ADD with no writeback
      5'd31: begin
        w_dec.is_halt = 1'b1;
      end
      // 18..30 are undefined: issue as a flagged no-op
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skid buffer: slot 0 is always the head, slot 1 the entry behind it
  // ---------------------------------------------------------------------------
  entry_t           r_slot [SKID_DEPTH];
  entry_t           w_slot_din [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] w_slot_we;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_accept_open;

  state_t r_state;
  state_t w_state_next;
  logic   r_halted;

  assign out_valid = (r_count != '0);
  assign in_ready  = w_accept_open & ~r_halted &
                     ((r_count < CNT_W'(SKID_DEPTH)) | out_ready);
  // a flushed cycle's word is accepted on the wire but never stored
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;

  // Slot steering: a pop shifts slot 1 forward, a push lands behind the survivors.
  always_comb begin
    w_slot_we = '0;
    for (int i = 0; i < SKID_DEPTH; i++) begin
      w_slot_din[i] = w_dec;
    end
    if (!flush) begin
      if (w_pop) begin
        if (r_count == CNT_W'(2)) begin
          w_slot_we[0]  = 1'b1;
          w_slot_din[0] = r_slot[1];
          w_slot_we[1]  = w_push;
        end else begin
          w_slot_we[0]  = w_push;
        end
      end else if (w_push) begin
        if (r_count == '0) begin
          w_slot_we[0] = 1'b1;
        end else begin
          w_slot_we[1] = 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_slot
      // Each slot loads its steered value; reset clears it so out_* read zero.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_slot[gi] <= '0;
        end else if (w_slot_we[gi]) begin
          r_slot[gi] <= w_slot_din[gi];
        end
      end
    end
  endgenerate

  // Occupancy: flush empties the buffer, otherwise track push minus pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // HALT tracking FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: an accepted HALT closes the input until a flush.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN && w_push && w_dec.is_halt) begin
      w_state_next = ST_HALT_SEEN;
    end
  end

  // State outputs: the input side is only open while running.
  always_comb begin
    w_accept_open = (r_state == ST_RUN);
  end

  // halted rises once the HALT entry has actually been consumed downstream.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_halted <= 1'b0;
    end else if (w_pop && r_slot[0].is_halt) begin
      r_halted <= 1'b1;
    end
  end

  assign halted        = r_halted;
  assign out_pc        = r_slot[0].pc;
  assign out_op        = r_slot[0].op;
  assign out_rd        = r_slot[0].rd;
  assign out_rs1       = r_slot[0].rs1;
  assign out_rs2       = r_slot[0].rs2;
  assign out_imm       = r_slot[0].imm;
  assign out_reg_write = r_slot[0].reg_write;
  assign out_is_branch = r_slot[0].is_branch;
  assign out_is_jump   = r_slot[0].is_jump;
  assign out_illegal   = r_slot[0].illegal;

endmodule
